pulse_sequencer: RTL and testbench
==================================

Name: pulse_sequencer

Overview:
- Programmable scheduler for a tick-period pulse datapath. It holds a small table of (period, repeat-count) steps and runs them in order.
- It emits single-cycle pulses at each step's period and moves to the next step after that step's repeat count.
- It sits between a CPU-style config/control interface and downstream consumers of timed strobes (LED blink patterns, buzzer tones, sample strobes).

Parameters:
- N, 8, width of the per-step period field (ticks).
- C, 8, width of the per-step repeat-count field.
- DEPTH, 4, number of step-table entries; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- ena  input  1  count enable; when low, RUN-state counting freezes.
- cfg_we  input  1  step-table write strobe.
- cfg_addr  input  $clog2(DEPTH)  table entry written.
- cfg_ticks  input  N  period value written.
- cfg_reps  input  C  repeat count written.
- num_steps  input  $clog2(DEPTH)+1  number of steps to run; sampled on an accepted start.
- start  input  1  begin a sequence; honoured only in IDLE.
- abort  input  1  stop immediately.
- out  output  1  registered pulse, high for one cycle per period.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle completion strobe.
- step  output  $clog2(DEPTH)  current step index.

Behaviour:
- Reset: state=IDLE; out=0, busy=0, done=0, step=0; counter and pulse count are 0; every table entry is ticks=0, reps=0.
- Table writes: a write on cfg_we updates entry cfg_addr at the clock edge and is accepted in any state. A running step uses the values latched at its LOAD, so a write to the active entry takes effect only at that entry's next LOAD.
- States: IDLE, LOAD, RUN, DONE. out and done default to 0 every cycle.
- IDLE:
  - start=1 latches num_steps and sets step=0.
  - If num_steps=0, go to DONE; otherwise go to LOAD.
  - num_steps > DEPTH is clamped to DEPTH.
- LOAD:
  - Latch act_ticks=table[step].ticks and act_reps=table[step].reps; clear counter and pulse count.
  - If act_reps=0, skip the step without pulsing: advance as at step end.
  - Otherwise go to RUN. LOAD lasts exactly one cycle and ignores ena.
- RUN:
  - If ena=0, hold all state.
  - If ena=1 and counter != act_ticks, increment counter.
  - If ena=1 and counter == act_ticks: set out<=1, clear counter, increment pulse count.
  - When the incremented pulse count equals act_reps, the step ends.
  - Period is act_ticks+1 enabled cycles; act_ticks=0 pulses every enabled cycle.
- Step end:
  - If step == num_steps-1, go to DONE.
  - Otherwise step+1, then LOAD.
  - The final pulse of a step and the state change happen on the same edge.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. step holds its last value until the next accepted start.
- Timing:
  - start sampled at edge E0. The first out is high in the cycle after edge E0+act_ticks+2.
  - Later pulses within a step are act_ticks+1 enabled cycles apart.
  - Across a step boundary there is one extra cycle for LOAD.
  - done is high in the same cycle as the final out pulse.
- abort:
  - Highest priority after rst, in any state: go to IDLE next edge.
  - out=0, done=0, busy=0; the table is preserved.
  - abort and start together in IDLE: abort wins and the sequence does not start.
- start while busy or in DONE is ignored (no queuing).
- Counter and pulse-count widths are N and C; the equality compares mean neither can wrap.

Optional Feature:
- Macro: PULSE_SEQUENCER_LOOP_EN.
- Defined: at the last step's end with num_steps>0, the block goes to LOAD with step=0 instead of DONE. done pulses for one cycle on each wrap, and busy stays high. The sequence repeats until abort or rst.
- Undefined: single pass as described above; a single pass is the default build.

Test Plan:
- Reset/idle: hold rst 2 cycles, then idle 5 cycles -> out=0, busy=0, done=0, step=0 throughout.
- Single step: table[0]=(ticks=3, reps=2), num_steps=1, start at E0 with ena=1 -> out high after edges E0+5 and E0+9; done high with the second pulse; busy low from E0+9; IDLE next.
- Multi-step with skip: table[0]=(1,1), table[1]=(5,0), table[2]=(0,3), num_steps=3:
  - out after E0+3, then after E0+4 (LOAD step1), E0+5 (skip to LOAD step2), E0+6, E0+7 and E0+8.
  - done with the last of those pulses.
  - step sequences 0,1,2.
- ena gating and abort: table[0]=(4,5); drop ena for 3 cycles mid-period -> pulse delayed by exactly 3 cycles. Then assert abort -> IDLE next edge, no done, table contents unchanged on re-run.
- Boundaries: num_steps=0 -> done one cycle after start with no out. start while busy -> ignored. ticks=255 with N=8 -> period 256 cycles, no wrap.
- Loop build (PULSE_SEQUENCER_LOOP_EN): table[0]=(2,1), num_steps=1 -> out every 4 cycles indefinitely, done coincident with each out, busy stays 1 until abort.

Source files
------------

// File: rtl/pulse_sequencer_if.sv
// Control, config and strobe bundle for pulse_sequencer.
// The master side drives the config/control inputs; the slave side is the sequencer.
interface pulse_sequencer_if #(
  parameter int N     = 8,
  parameter int C     = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          ena;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [N-1:0]  cfg_ticks;
  logic [C-1:0]  cfg_reps;
  logic [AW:0]   num_steps;
  logic          start;
  logic          abort;
  logic          out;
  logic          busy;
  logic          done;
  logic [AW-1:0] step;
  logic [1:0]    dbg_state;

  // Level-style controls: no valid/ready handshake. start is a request that
  // is accepted only while the sequencer is idle and abort is low. A start
  // that is not accepted is dropped, never queued. cfg_we commits one table
  // write on every edge where it is high, in any state.
  modport master (
    output ena, cfg_we, cfg_addr, cfg_ticks, cfg_reps, num_steps, start, abort,
    input  out, busy, done, step, dbg_state
  );

  modport slave (
    input  ena, cfg_we, cfg_addr, cfg_ticks, cfg_reps, num_steps, start, abort,
    output out, busy, done, step, dbg_state
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Table-driven pulse scheduler: runs (period, repeat) steps in order, emitting one-cycle strobes.
// Define PULSE_SEQUENCER_LOOP_EN to wrap back to step 0 forever instead of finishing after one pass.
module pulse_sequencer #(
  parameter int N     = 8,
  parameter int C     = 8,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  pulse_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

`ifdef PULSE_SEQUENCER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  tbl_ticks [DEPTH];
  logic [C-1:0]  tbl_reps  [DEPTH];
  logic [N-1:0]  act_ticks, cnt;
  logic [C-1:0]  act_reps, pcnt;
  logic [AW-1:0] step_q;
  logic [AW:0]   nsteps;
  logic          out_q, done_q;
  logic          pulse_hit, step_end, skip, adv, last, finish;

  always_comb begin
    pulse_hit = (state == RUN) && bus.ena && (cnt == act_ticks);
    step_end  = pulse_hit && ((pcnt + C'(1)) == act_reps);
    skip      = (state == LOAD) && (tbl_reps[step_q] == '0);
    adv       = step_end || skip;
    last      = ({1'b0, step_q} == (nsteps - (AW+1)'(1)));
    // done rises on the edge that retires the final step (or an empty run)
    finish    = (adv && last) || ((state == IDLE) && bus.start && (bus.num_steps == '0));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.num_steps == '0) ? DONE : LOAD;
      LOAD, RUN: begin
        if (adv)                state_nxt = (last && !LOOP_EN) ? DONE : LOAD;
        else if (state == LOAD) state_nxt = RUN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  // Output logic
  always_comb begin
    bus.busy      = (state == LOAD) || (state == RUN);
    bus.dbg_state = state;
    bus.out       = out_q;
    bus.done      = done_q;
    bus.step      = step_q;
  end

  // Step table and run datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_ticks[i] <= '0;
        tbl_reps[i]  <= '0;
      end
      act_ticks <= '0;
      act_reps  <= '0;
      cnt       <= '0;
      pcnt      <= '0;
      step_q    <= '0;
      nsteps    <= '0;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        tbl_ticks[bus.cfg_addr] <= bus.cfg_ticks;
        tbl_reps[bus.cfg_addr]  <= bus.cfg_reps;
      end
      if (bus.abort) begin
        out_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        out_q  <= pulse_hit;
        done_q <= finish;
        case (state)
          IDLE: if (bus.start) begin
            nsteps <= (bus.num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_steps;
            step_q <= '0;
          end
          LOAD: begin
            act_ticks <= tbl_ticks[step_q];
            act_reps  <= tbl_reps[step_q];
            cnt       <= '0;
            pcnt      <= '0;
          end
          RUN: if (bus.ena) begin
            cnt  <= pulse_hit ? '0 : cnt + N'(1);
            pcnt <= pulse_hit ? pcnt + C'(1) : pcnt;
          end
          default: ;
        endcase
        if (adv) begin
          if (!last)       step_q <= step_q + AW'(1);
          else if (LOOP_EN) step_q <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: a timeline model predicts out/done/busy/step per cycle,
// a negedge process compares every cycle, and literal cycle numbers pin the model.
module tb_pulse_sequencer;
  localparam int N = 8, C = 8, DEPTH = 4, AW = 2, MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_sequencer_if #(.N(N), .C(C), .DEPTH(DEPTH)) bus();
  pulse_sequencer #(.N(N), .C(C), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic exp_out [MAXC], exp_done [MAXC], exp_busy [MAXC];
  int   exp_step [MAXC];
  logic out_h [MAXC], done_h [MAXC], busy_h [MAXC];
  int   step_h [MAXC];
  bit   ena_arr [MAXC];
  int   mt_ticks [DEPTH], mt_reps [DEPTH];
  int   vectors = 0, miscompares = 0;
  int   e0, a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic void fill_idle(input int from, input int s);
    for (int k = from; k < MAXC; k++) begin
      exp_out[k] = 1'b0; exp_done[k] = 1'b0; exp_busy[k] = 1'b0; exp_step[k] = s;
    end
  endfunction

  // Cycle k means the interval after posedge k; start is sampled at edge e0.
  function automatic void predict(input int e0_i, input int n);
    int ne, k, s, e, cnt, pulses;
    bit o;
    ne = (n > DEPTH) ? DEPTH : n;
    k = e0_i; s = 0;
    if (ne == 0) begin
      fill_idle(e0_i, 0);
      exp_done[e0_i] = 1'b1;
      return;
    end
    while (k < MAXC - 2) begin
      exp_busy[k] = 1'b1; exp_step[k] = s;
      if (mt_reps[s] == 0) e = k + 1;
      else begin
        exp_busy[k+1] = 1'b1; exp_step[k+1] = s;
        e = k + 2; cnt = 0; pulses = 0;
        while (e < MAXC) begin
          if (ena_arr[e]) begin
            cnt++;
            if (cnt == mt_ticks[s] + 1) begin
              exp_out[e] = 1'b1; cnt = 0; pulses++;
              if (pulses == mt_reps[s]) break;
            end
          end
          exp_busy[e] = 1'b1; exp_step[e] = s;
          e++;
        end
      end
      if (e >= MAXC) return;
      if (s == ne - 1) begin
`ifdef PULSE_SEQUENCER_LOOP_EN
        exp_done[e] = 1'b1;
        s = 0; k = e;
`else
        o = exp_out[e];
        fill_idle(e, s);
        exp_out[e] = o; exp_done[e] = 1'b1;
        return;
`endif
      end else begin
        s++; k = e;
      end
    end
  endfunction

  always @(negedge clk) bus.ena = (cyc + 1 < MAXC) ? ena_arr[cyc+1] : 1'b1;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      out_h[cyc] = bus.out; done_h[cyc] = bus.done; busy_h[cyc] = bus.busy; step_h[cyc] = 32'(bus.step);
      chk($sformatf("out@%0d", cyc), bus.out, exp_out[cyc]);
      chk($sformatf("done@%0d", cyc), bus.done, exp_done[cyc]);
      chk($sformatf("busy@%0d", cyc), bus.busy, exp_busy[cyc]);
      chk($sformatf("step@%0d", cyc), 32'(bus.step), exp_step[cyc]);
    end
  end

  task automatic wr(input int adr, input int t, input int r);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = AW'(adr); bus.cfg_ticks = N'(t); bus.cfg_reps = C'(r);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    mt_ticks[adr] = t; mt_reps[adr] = r;
  endtask

  task automatic go(input int n, input int hole_off, input int hole_len, output int e0_o);
    @(negedge clk);
    e0_o = cyc + 1;
    for (int i = 0; i < hole_len; i++) ena_arr[e0_o + hole_off + i] = 1'b0;
    bus.num_steps = (AW+1)'(n); bus.start = 1'b1;
    predict(e0_o, n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic poke_start(input int n);
    @(negedge clk);
    bus.num_steps = (AW+1)'(n); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic abort_now(output int a_o);
    @(negedge clk);
    bus.abort = 1'b1;
    a_o = cyc + 1;
    fill_idle(a_o, exp_step[a_o-1]);
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_ticks = '0; bus.cfg_reps = '0;
    bus.num_steps = '0; bus.start = 1'b0; bus.abort = 1'b0;
    for (int i = 0; i < MAXC; i++) ena_arr[i] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin mt_ticks[i] = 0; mt_reps[i] = 0; end
    fill_idle(0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_n(5);

`ifdef PULSE_SEQUENCER_LOOP_EN
    wr(0, 2, 1);
    go(1, 0, 0, e0);
    wait_n(20);
    chk("loop_p1", out_h[e0+4], 1);
    chk("loop_p2", out_h[e0+8], 1);
    chk("loop_p4", out_h[e0+16], 1);
    chk("loop_gap", out_h[e0+6], 0);
    chk("loop_done", done_h[e0+12], 1);
    chk("loop_busy", busy_h[e0+16], 1);
    abort_now(a);
    wait_n(4);
    chk("loop_abort_busy", busy_h[a], 0);
    chk("loop_abort_out", out_h[a+1], 0);
`else
    // single step (3,2)
    wr(0, 3, 2);
    go(1, 0, 0, e0);
    wait_n(14);
    chk("single_p1", out_h[e0+5], 1);
    chk("single_gap", out_h[e0+6], 0);
    chk("single_p2", out_h[e0+9], 1);
    chk("single_done", done_h[e0+9], 1);
    chk("single_busy_hi", busy_h[e0+8], 1);
    chk("single_busy_lo", busy_h[e0+9], 0);

    // multi-step with a zero-repeat step skipped
    wr(0, 1, 1); wr(1, 5, 0); wr(2, 0, 3);
    go(3, 0, 0, e0);
    wait_n(12);
    chk("multi_p1", out_h[e0+3], 1);
    chk("multi_skip", out_h[e0+4], 0);
    chk("multi_p2", out_h[e0+6], 1);
    chk("multi_p4", out_h[e0+8], 1);
    chk("multi_done", done_h[e0+8], 1);
    chk("multi_step0", step_h[e0+2], 0);
    chk("multi_step1", step_h[e0+3], 1);
    chk("multi_step2", step_h[e0+4], 2);

    // ena hole of 3 edges delays the first pulse by 3; abort lands on the 2nd pulse edge
    wr(0, 4, 5);
    go(1, 4, 3, e0);
    wait_n(12);
    chk("ena_no_early", out_h[e0+6], 0);
    chk("ena_not_e8", out_h[e0+8], 0);
    chk("ena_p1", out_h[e0+9], 1);
    abort_now(a);
    wait_n(4);
    chk("abort_busy", busy_h[a], 0);
    chk("abort_out", out_h[a], 0);
    chk("abort_done", done_h[a+1], 0);
    go(1, 0, 0, e0);
    wait_n(30);
    chk("rerun_p1", out_h[e0+6], 1);
    chk("rerun_p5", out_h[e0+26], 1);
    chk("rerun_done", done_h[e0+26], 1);

    // empty run
    go(0, 0, 0, e0);
    wait_n(3);
    chk("zero_done", done_h[e0], 1);
    chk("zero_busy", busy_h[e0], 0);
    chk("zero_done_once", done_h[e0+1], 0);

    // start while busy is dropped; a write to the active entry waits for its next LOAD
    wr(0, 3, 2);
    go(1, 0, 0, e0);
    wait_n(1);
    poke_start(2);
    wr(0, 1, 1);
    wait_n(8);
    chk("busy_start_p2", out_h[e0+9], 1);
    chk("busy_start_done", done_h[e0+9], 1);
    go(1, 0, 0, e0);
    wait_n(6);
    chk("newtbl_p1", out_h[e0+3], 1);
    chk("newtbl_done", done_h[e0+3], 1);

    // num_steps above DEPTH is clamped
    wr(1, 0, 1); wr(2, 0, 0); wr(3, 0, 1);
    go(7, 0, 0, e0);
    wait_n(12);
    chk("clamp_p3", out_h[e0+8], 1);
    chk("clamp_done", done_h[e0+8], 1);
    chk("clamp_step", step_h[e0+8], 3);

    // maximum period
    wr(0, 255, 1);
    go(1, 0, 0, e0);
    wait_n(262);
    chk("wide_early", out_h[e0+256], 0);
    chk("wide_p1", out_h[e0+257], 1);
    chk("wide_done", done_h[e0+257], 1);
`endif
    wait_n(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
